// File: rtl/mips_pkg.sv
// Shared pipeline-control types: register-index width and controller FSM encodings.
// Latency: none (declarations only). Backpressure: not applicable.
// Imported by the hazard unit, the interface and the controller.
package mips_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_MD_WAIT = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage write-enable/squash outputs between datapath and controller.
// Latency: wires only. Backpressure: pc_write/ifid_write low stall the front end.
// master = pipeline datapath, slave = pipeline_ctrl.
interface pipeline_ctrl_if;
   import mips_pkg::*;

   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rt;
   logic             ex_mem_read;
   logic [REG_W-1:0] ex_rt;
   logic             exe_use_npc;
   logic             md_start;
   logic             md_done;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_bubble;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
             exe_use_npc, md_start, md_done,
      input  pc_write, ifid_write, ifid_flush, idex_bubble
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
             exe_use_npc, md_start, md_done,
      output pc_write, ifid_write, ifid_flush, idex_bubble
   );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator between the load in EX and the source registers in ID.
// Latency: combinational. Backpressure: none; result feeds the stall decision.
// Register zero never creates a dependency.
module hazard_detect
   import mips_pkg::*;
(
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   output logic             load_use
);

   assign load_use = ex_mem_read && (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch squash, mult/div wait with timeout.
// Latency: enables/squashes are combinational from state and inputs; state changes next cycle.
// Backpressure: drops pc_write/ifid_write to hold the front end; PIPELINE_CTRL_PERF_EN adds counters.
module pipeline_ctrl
   import mips_pkg::*;
#(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic             clock,
   input  logic             reset,
   pipeline_ctrl_if.slave   pif,
   output logic             md_error,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   localparam int TMR_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

   ctrl_state_t      state_q, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic             err_set;
   logic             load_use;

   hazard_detect u_hazard (
      .id_rs       (pif.id_rs),
      .id_rt       (pif.id_rt),
      .id_uses_rt  (pif.id_uses_rt),
      .ex_mem_read (pif.ex_mem_read),
      .ex_rt       (pif.ex_rt),
      .load_use    (load_use)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_RUN;
         timer    <= '0;
         md_error <= 1'b0;
      end else begin
         state_q <= state_nxt;
         timer   <= timer_nxt;
         if (err_set) md_error <= 1'b1;
      end
   end

   always_comb begin
      pif.pc_write    = 1'b1;
      pif.ifid_write  = 1'b1;
      pif.ifid_flush  = 1'b0;
      pif.idex_bubble = 1'b0;
      state_nxt       = ST_RUN;
      timer_nxt       = timer;
      err_set         = 1'b0;

      case (state_q)
         ST_FLUSH: begin
            pif.ifid_flush  = 1'b1;
            pif.idex_bubble = 1'b1;
         end
         ST_MD_WAIT: begin
            // md_done releases the pipeline in the same cycle with idle outputs
            if (!pif.md_done) begin
               pif.pc_write    = 1'b0;
               pif.ifid_write  = 1'b0;
               pif.idex_bubble = 1'b1;
               if (timer == TMR_LAST) begin
                  err_set = 1'b1;
               end else begin
                  state_nxt = ST_MD_WAIT;
                  timer_nxt = timer + 1'b1;
               end
            end
         end
         default: begin
            // RUN (and the unused encoding): branch > load-use > mult/div issue
            if (!pif.exe_use_npc) begin
               pif.ifid_flush  = 1'b1;
               pif.idex_bubble = 1'b1;
               state_nxt       = ST_FLUSH;
            end else if (load_use) begin
               pif.pc_write    = 1'b0;
               pif.ifid_write  = 1'b0;
               pif.idex_bubble = 1'b1;
            end else if (pif.md_start) begin
               pif.pc_write   = 1'b0;
               pif.ifid_write = 1'b0;
               state_nxt      = ST_MD_WAIT;
               timer_nxt      = '0;
            end
         end
      endcase

      if (reset) begin
         pif.pc_write    = 1'b1;
         pif.ifid_write  = 1'b1;
         pif.ifid_flush  = 1'b0;
         pif.idex_bubble = 1'b0;
      end
   end

   assign state = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_q, flush_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pif.pc_write)          stall_q <= stall_q + 1'b1;
         if (state_nxt == ST_FLUSH)  flush_q <= flush_q + 1'b1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_events = flush_q;
`else
   assign stall_cycles = {CNT_W{1'b0}};
   assign flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table through a scoreboard plus hand-written multi-cycle sequences.
// A second instance with MD_TIMEOUT=8 shares the stimulus for the timeout cases.
module tb_pipeline_ctrl;
   import mips_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   pipeline_ctrl_if pif ();
   pipeline_ctrl_if pif8 ();

   logic        md_error, md_error8;
   logic [1:0]  state, state8;
   logic [31:0] stall_cycles, flush_events, stall8, flush8;

   assign pif8.id_rs       = pif.id_rs;
   assign pif8.id_rt       = pif.id_rt;
   assign pif8.id_uses_rt  = pif.id_uses_rt;
   assign pif8.ex_mem_read = pif.ex_mem_read;
   assign pif8.ex_rt       = pif.ex_rt;
   assign pif8.exe_use_npc = pif.exe_use_npc;
   assign pif8.md_start    = pif.md_start;
   assign pif8.md_done     = pif.md_done;

   pipeline_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .pif          (pif),
      .md_error     (md_error),
      .state        (state),
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
   );

   pipeline_ctrl #(.MD_TIMEOUT(8)) dut8 (
      .clock        (clock),
      .reset        (reset),
      .pif          (pif8),
      .md_error     (md_error8),
      .state        (state8),
      .stall_cycles (stall8),
      .flush_events (flush8)
   );

   // {pc_write, ifid_write, ifid_flush, idex_bubble, state[1:0], md_error}
   localparam logic [6:0] RUN_IDLE = 7'b1100_00_0;
   localparam logic [6:0] STALL    = 7'b0001_00_0;
   localparam logic [6:0] BR       = 7'b1111_00_0;
   localparam logic [6:0] FLUSHST  = 7'b1111_01_0;
   localparam logic [6:0] MDISSUE  = 7'b0000_00_0;
   localparam logic [6:0] MDWAIT   = 7'b0001_10_0;
   localparam logic [6:0] MDDONE   = 7'b1100_10_0;

   typedef struct {
      logic [4:0] rs, rt;
      logic       uses_rt, mem_rd;
      logic [4:0] ex_rt;
      logic       npc, mds, mdd;
      logic [6:0] exp;
   } vec_t;

   vec_t tbl [20];
   vec_t sb [$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                               input logic mem, input logic [4:0] ert, input logic npc,
                               input logic mds, input logic mdd, input logic [6:0] exp);
      vec_t v;
      v.rs = rs; v.rt = rt; v.uses_rt = uses; v.mem_rd = mem; v.ex_rt = ert;
      v.npc = npc; v.mds = mds; v.mdd = mdd; v.exp = exp;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      pif.id_rs       = v.rs;
      pif.id_rt       = v.rt;
      pif.id_uses_rt  = v.uses_rt;
      pif.ex_mem_read = v.mem_rd;
      pif.ex_rt       = v.ex_rt;
      pif.exe_use_npc = v.npc;
      pif.md_start    = v.mds;
      pif.md_done     = v.mdd;
   endtask

   task automatic cyc(input vec_t v, output logic [6:0] om, output logic [6:0] o8);
      drive(v);
      @(negedge clock);
      om = {pif.pc_write, pif.ifid_write, pif.ifid_flush, pif.idex_bubble, state, md_error};
      o8 = {pif8.pc_write, pif8.ifid_write, pif8.ifid_flush, pif8.idex_bubble, state8, md_error8};
      @(posedge clock);
      #1;
   endtask

   task automatic step(input vec_t v, input string nm);
      vec_t       e;
      logic [6:0] om, o8;
      sb.push_back(v);
      cyc(v, om, o8);
      e = sb.pop_front();
      check(nm, 32'(om), 32'(e.exp));
   endtask

   task automatic do_reset();
      logic [6:0] om, o8;
      reset = 1'b1;
      cyc(mk(1, 2, 1, 0, 0, 1, 0, 0, RUN_IDLE), om, o8);
      reset = 1'b0;
   endtask

   initial begin
      vec_t       idle, v_br, v_mds, v_mdd;
      logic [6:0] om, o8;
      int         m_stall, m_flush, zc, waits, exp_stall, exp_flush;
      logic [3:0] fl_seq;
      logic [7:0] st_seq;

      idle  = mk(1, 2, 1, 0, 0, 1, 0, 0, RUN_IDLE);
      v_br  = mk(1, 2, 1, 0, 0, 0, 0, 0, BR);
      v_mds = mk(1, 2, 1, 0, 0, 1, 1, 0, MDISSUE);
      v_mdd = mk(1, 2, 1, 0, 0, 1, 0, 1, MDDONE);

      tbl[0]  = idle;
      tbl[1]  = mk(5, 2, 1, 1, 5, 1, 0, 0, STALL);
      tbl[2]  = idle;
      tbl[3]  = mk(0, 2, 1, 1, 0, 1, 0, 0, RUN_IDLE);
      tbl[4]  = mk(3, 7, 1, 1, 7, 1, 0, 0, STALL);
      tbl[5]  = mk(3, 7, 0, 1, 7, 1, 0, 0, RUN_IDLE);
      tbl[6]  = mk(8, 10, 1, 1, 9, 1, 0, 0, RUN_IDLE);
      tbl[7]  = mk(5, 5, 1, 0, 5, 1, 0, 0, RUN_IDLE);
      tbl[8]  = v_br;
      tbl[9]  = mk(5, 2, 1, 1, 5, 0, 1, 0, FLUSHST);
      tbl[10] = idle;
      tbl[11] = mk(5, 2, 1, 1, 5, 0, 1, 0, BR);
      tbl[12] = mk(1, 2, 1, 0, 0, 1, 0, 0, FLUSHST);
      tbl[13] = mk(5, 2, 1, 1, 5, 1, 1, 0, STALL);
      tbl[14] = idle;
      tbl[15] = v_mds;
      tbl[16] = mk(1, 2, 1, 0, 0, 0, 0, 0, MDWAIT);
      tbl[17] = mk(5, 2, 1, 1, 5, 1, 1, 0, MDWAIT);
      tbl[18] = v_mdd;
      tbl[19] = mk(1, 2, 1, 0, 0, 1, 0, 1, RUN_IDLE);

      // power-on reset
      reset = 1'b1;
      drive(idle);
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      check("reset_outputs", 32'({pif.pc_write, pif.ifid_write, pif.ifid_flush, pif.idex_bubble}), 32'b1100);
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("reset_state", 32'(state), 32'(ST_RUN));
      check("reset_md_error", 32'(md_error), 32'd0);
      check("reset_counters", stall_cycles | flush_events, 32'd0);

      m_stall = 0;
      m_flush = 0;
      for (int i = 0; i < 20; i++) begin
         step(tbl[i], $sformatf("row%0d", i));
         if (!tbl[i].exp[6]) m_stall++;
         if (tbl[i].exp[4] && tbl[i].exp[2:1] == 2'd0) m_flush++;
      end
`ifdef PIPELINE_CTRL_PERF_EN
      exp_stall = m_stall;
      exp_flush = m_flush;
`else
      exp_stall = 0;
      exp_flush = 0;
`endif
      check("table_stall_cycles", stall_cycles, 32'(exp_stall));
      check("table_flush_events", flush_events, 32'(exp_flush));

      // taken branch: two-cycle squash, state 0 -> 1 -> 0
      do_reset();
      fl_seq = '0;
      st_seq = '0;
      for (int i = 0; i < 4; i++) begin
         cyc((i == 0) ? v_br : idle, om, o8);
         fl_seq[3 - i] = om[4];
         st_seq[7 - 2*i -: 2] = om[2:1];
      end
      check("branch_flush_seq", 32'(fl_seq), 32'b1100);
      check("branch_state_seq", 32'(st_seq), 32'b00_01_00_00);
`ifdef PIPELINE_CTRL_PERF_EN
      exp_flush = 1;
`else
      exp_flush = 0;
`endif
      check("branch_flush_events", flush_events, 32'(exp_flush));

      // mult/div: issue, 10 waiting cycles, then md_done
      do_reset();
      zc = 0;
      cyc(v_mds, om, o8);
      if (!om[6]) zc++;
      for (int i = 0; i < 10; i++) begin
         cyc(idle, om, o8);
         if (!om[6]) zc++;
      end
      cyc(v_mdd, om, o8);
      if (!om[6]) zc++;
      check("md_done_outputs", 32'(om), 32'(MDDONE));
      check("md_stall_count", 32'(zc), 32'd11);
      check("md_state_after", 32'(state), 32'(ST_RUN));
`ifdef PIPELINE_CTRL_PERF_EN
      exp_stall = 11;
`else
      exp_stall = 0;
`endif
      check("md_stall_cycles", stall_cycles, 32'(exp_stall));

      // timeout on the MD_TIMEOUT=8 instance
      do_reset();
      cyc(v_mds, om, o8);
      waits = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(idle, om, o8);
         if (o8[2:1] != 2'(ST_MD_WAIT)) break;
         waits++;
      end
      check("timeout_wait_cycles", 32'(waits), 32'd8);
      check("timeout_state", 32'(state8), 32'(ST_RUN));
      check("timeout_md_error", 32'(md_error8), 32'd1);
      for (int i = 0; i < 5; i++) cyc(idle, om, o8);
      check("md_error_sticky", 32'(md_error8), 32'd1);
      check("main_still_waiting", 32'(state), 32'(ST_MD_WAIT));

      // reset while waiting
      reset = 1'b1;
      cyc(idle, om, o8);
      reset = 1'b0;
      check("reset_in_wait_outputs", 32'(om[6:3]), 32'b1100);
      check("reset_in_wait_state", 32'({state, state8}), 32'd0);
      check("reset_in_wait_md_error", 32'({md_error, md_error8}), 32'd0);
      check("reset_in_wait_counters", stall_cycles | flush_events, 32'd0);
      cyc(idle, om, o8);
      check("after_reset_idle", 32'(om), 32'(RUN_IDLE));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
